// File: rtl/ifmap_pkg.sv
// Shared IFMap scratchpad definitions: controller state encoding and default
// geometry, used by the write controller and the read address generator.
package ifmap_pkg;

  localparam int DEF_IF_LENGTH  = 12;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } ifmap_state_e;

endpackage

// File: rtl/ifmap_ptr_wrap.sv
// Modulo-IF_LENGTH pointer adder: ptr_next = (ptr + inc) mod IF_LENGTH.
// Relies on ptr < IF_LENGTH and inc <= IF_LENGTH, so one conditional subtract suffices.
module ifmap_ptr_wrap #(
  parameter int ADDR_WIDTH = 16,
  parameter int IF_LENGTH  = 12,
  parameter int INC_WIDTH  = 4
) (
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  logic [INC_WIDTH-1:0]  inc,
  output logic [ADDR_WIDTH-1:0] ptr_next
);

  localparam logic [ADDR_WIDTH:0] LEN = (ADDR_WIDTH+1)'(IF_LENGTH);

  logic [ADDR_WIDTH:0] sum;

  assign sum      = {1'b0, ptr} + (ADDR_WIDTH+1)'(inc);
  assign ptr_next = (sum >= LEN) ? ADDR_WIDTH'(sum - LEN) : ADDR_WIDTH'(sum);

endmodule

// File: rtl/ifmap_write_controller.sv
// Write side of the IFMap circular scratchpad: streams words in at a wrapping
// write pointer, tracks occupancy and the read base pointer freed by stride releases.
// Optional sticky overrun flag ovr_err is built when IFMAP_WR_OVERRUN_CHK_EN is defined.
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready are both
// high; in_ready depends only on registered state/occupancy, never on in_valid.
module ifmap_write_controller
  import ifmap_pkg::*;
#(
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int IF_LENGTH         = DEF_IF_LENGTH,
  parameter int STRIDE_WIDTH      = 4,
  parameter int FILTER_SIZE_WIDTH = 4,
  parameter int CNT_WIDTH         = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         release_valid,
  input  logic [STRIDE_WIDTH-1:0]      release_count,
  output logic [ADDR_WIDTH-1:0]        IF_start_addr,
  output logic [CNT_WIDTH-1:0]         occupancy,
  output logic                         window_valid,
  output logic                         row_done,
`ifdef IFMAP_WR_OVERRUN_CHK_EN
  output logic                         ovr_err,
`endif
  output ifmap_state_e                 dbg_state
);

  localparam int RW = (CNT_WIDTH > STRIDE_WIDTH) ? CNT_WIDTH : STRIDE_WIDTH;

  ifmap_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
  logic [CNT_WIDTH-1:0]  occ;
  logic [RW-1:0]         rel_w, occ_w, eff;
  logic                  hs, row_start;

  assign hs        = in_valid & in_ready;
  assign row_start = (state == IDLE) & start;
  assign rel_w     = RW'(release_count);
  assign occ_w     = RW'(occ);

  // Over-release saturates at the current occupancy.
  always_comb begin
    eff = '0;
    if (release_valid) eff = (rel_w < occ_w) ? rel_w : occ_w;
  end

  ifmap_ptr_wrap #(.ADDR_WIDTH(ADDR_WIDTH), .IF_LENGTH(IF_LENGTH), .INC_WIDTH(1)) u_wr_wrap (
    .ptr     (wr_ptr),
    .inc     (1'b1),
    .ptr_next(wr_ptr_inc)
  );

  ifmap_ptr_wrap #(.ADDR_WIDTH(ADDR_WIDTH), .IF_LENGTH(IF_LENGTH), .INC_WIDTH(RW)) u_rd_wrap (
    .ptr     (rd_ptr),
    .inc     (eff),
    .ptr_next(rd_ptr_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (hs && in_last) state_nxt = DRAIN;
      DRAIN:   if (occ == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state == FILL) && (occ != CNT_WIDTH'(IF_LENGTH));
    row_done     = (state == DRAIN) && (occ == '0);
    window_valid = (state != IDLE) && (32'(occ) >= 32'(filter_size));
  end

  // Write port is driven to zero outside a handshake so idle/reset presents all zeros.
  assign wr_en   = hs;
  assign wr_addr = hs ? wr_ptr : '0;
  assign wr_data = hs ? in_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (row_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (hs) wr_ptr <= wr_ptr_inc;
      rd_ptr <= rd_ptr_inc;
      occ    <= occ + CNT_WIDTH'(hs) - CNT_WIDTH'(eff);
    end
  end

`ifdef IFMAP_WR_OVERRUN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovr_err <= 1'b0;
    else if (row_start) ovr_err <= 1'b0;
    else if ((release_valid && (rel_w > occ_w)) || ((state == DRAIN) && in_valid))
      ovr_err <= 1'b1;
  end
`endif

  assign IF_start_addr = rd_ptr;
  assign occupancy     = occ;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ifmap_write_controller.sv
// Randomized scoreboard bench for ifmap_write_controller against a queue/arithmetic
// model of the circular scratchpad (row phase, occupancy, read/write positions).
module tb_ifmap_write_controller;
  import ifmap_pkg::*;

  localparam int L = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [3:0]  filter_size = 4'd3;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready, wr_en;
  logic [15:0] wr_addr, wr_data;
  logic        release_valid = 1'b0;
  logic [3:0]  release_count = '0;
  logic [15:0] IF_start_addr;
  logic [4:0]  occupancy;
  logic        window_valid, row_done;
  ifmap_state_e dbg_state;
`ifdef IFMAP_WR_OVERRUN_CHK_EN
  logic        ovr_err;
`endif

  ifmap_write_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filter_size(filter_size),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .release_valid(release_valid), .release_count(release_count),
    .IF_start_addr(IF_start_addr), .occupancy(occupancy),
    .window_valid(window_valid), .row_done(row_done),
`ifdef IFMAP_WR_OVERRUN_CHK_EN
    .ovr_err(ovr_err),
`endif
    .dbg_state(dbg_state)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // reference model: 0 = idle, 1 = filling, 2 = draining
  int m_phase = 0;
  int m_occ = 0;
  int m_wr = 0;
  int m_rd = 0;
  bit m_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every scratchpad write must match the oldest expected write
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                 wr_addr, wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("write", {wr_addr, wr_data}, e);
      end
    end
  end

  // driver: apply one cycle of stimulus, check registered outputs, advance model
  task automatic cycle(input bit v, input bit last, input bit rv, input int rc, input bit st);
    logic [15:0] d;
    bit exp_ready, hs;
    int eff;
    d = 16'($urandom);
    in_valid = v; in_data = d; in_last = last;
    release_valid = rv; release_count = 4'(rc); start = st;
    exp_ready = (m_phase == 1) && (m_occ != L);
    hs = v && exp_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("occupancy", 32'(occupancy), 32'(m_occ));
    chk("if_start_addr", 32'(IF_start_addr), 32'(m_rd));
    chk("window_valid", 32'(window_valid), 32'((m_phase != 0) && (m_occ >= int'(filter_size))));
    chk("row_done", 32'(row_done), 32'((m_phase == 2) && (m_occ == 0)));
    chk("state", 32'(dbg_state), 32'(m_phase));
`ifdef IFMAP_WR_OVERRUN_CHK_EN
    chk("ovr_err", 32'(ovr_err), 32'(m_ovr));
`endif
    if (hs) exp_q.push_back({16'(m_wr), d});
    if (m_phase == 0 && st) begin
      m_phase = 1; m_occ = 0; m_wr = 0; m_rd = 0; m_ovr = 1'b0;
    end else begin
      if ((rv && rc > m_occ) || (m_phase == 2 && v)) m_ovr = 1'b1;
      eff = rv ? ((rc < m_occ) ? rc : m_occ) : 0;
      if (m_phase == 2 && m_occ == 0) m_phase = 0;
      else if (m_phase == 1 && hs && last) m_phase = 2;
      if (hs) m_wr = (m_wr + 1) % L;
      m_rd = (m_rd + eff) % L;
      m_occ = m_occ + (hs ? 1 : 0) - eff;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_occupancy"}, 32'(occupancy), 0);
    chk({tag, "_if_start_addr"}, 32'(IF_start_addr), 0);
    chk({tag, "_window_valid"}, 32'(window_valid), 0);
    chk({tag, "_row_done"}, 32'(row_done), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill to full, then keep offering words while full
    cycle(0, 0, 0, 0, 1);
    repeat (14) cycle(1, 0, 0, 0, 0);

    // wrap: free 4, next writes land at 0..3
    cycle(0, 0, 1, 4, 0);
    repeat (4) cycle(1, 0, 0, 0, 0);

    // simultaneous write and release from occupancy 5
    cycle(0, 0, 1, 7, 0);
    cycle(1, 0, 1, 2, 0);

    // over-release from occupancy 2
    cycle(0, 0, 1, 2, 0);
    cycle(0, 0, 1, 5, 0);
    cycle(0, 0, 0, 0, 0);

    // randomized traffic inside the row, with ignored start pulses
    for (int i = 0; i < 240; i++) begin
      if (i % 40 == 0) begin
        filter_size = 4'($urandom_range(0, 15));
        #1;
      end
      cycle($urandom_range(0, 3) != 0, 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, L), $urandom_range(0, 15) == 0);
    end
    filter_size = 4'd3;
    #1;

    // close the current row and drain it
    cycle(0, 0, 1, L, 0);
    cycle(1, 1, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 3, 0);

    // new row ending on the 6th word, drained by 3 + 3
    cycle(0, 0, 0, 0, 1);
    repeat (5) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 3, 0);
    cycle(0, 0, 1, 3, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);

    // asynchronous reset mid-row with occupancy 7
    cycle(0, 0, 0, 0, 1);
    repeat (7) cycle(1, 0, 0, 0, 0);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrow_reset");
    m_phase = 0; m_occ = 0; m_wr = 0; m_rd = 0; m_ovr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    repeat (3) cycle(1, 0, 1, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifmap_write_controller.md
Name: ifmap_write_controller

Overview:
- Write side of the IFMap circular scratchpad.
- Accepts the incoming IFMap stream over a valid/ready handshake and writes each word at a wrap-around write pointer modulo IF_LENGTH.
- Owns the read base pointer (IF_start_addr) and occupancy. The read-side address generator consumes the window, then returns freed entries via a stride release.
- Sits between the global-buffer stream and the IFMap scratchpad; paired with the read address generator in each PE.

Parameters:
- ADDR_WIDTH, 16, scratchpad address width.
- DATA_WIDTH, 16, IFMap word width.
- IF_LENGTH, 12, scratchpad depth in words; pointers wrap at this value.
- STRIDE_WIDTH, 4, width of the release/stride amount.
- FILTER_SIZE_WIDTH, 4, width of the filter size.
- CNT_WIDTH, 5, occupancy counter width; must hold 0..IF_LENGTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new row.
- filter_size  in  FILTER_SIZE_WIDTH  window length required before compute.
- in_valid  in  1  input word valid.
- in_data  in  DATA_WIDTH  input word.
- in_last  in  1  qualifies the last word of the row.
- in_ready  out  1  controller accepts a word this cycle.
- wr_en  out  1  scratchpad write strobe.
- wr_addr  out  ADDR_WIDTH  scratchpad write address.
- wr_data  out  DATA_WIDTH  scratchpad write data.
- release_valid  in  1  reader frees entries this cycle.
- release_count  in  STRIDE_WIDTH  number of entries freed (stride).
- IF_start_addr  out  ADDR_WIDTH  read base pointer for the read address generator.
- occupancy  out  CNT_WIDTH  valid words held.
- window_valid  out  1  occupancy >= filter_size.
- row_done  out  1  row fully written and fully released.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_ptr=0, rd_ptr=0, occupancy=0.
  - in_ready=0, wr_en=0, window_valid=0, row_done=0.
  - IF_start_addr=0; wr_addr=0; wr_data=0.
  - Reset mid-row discards all contents; no partial writes complete.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - in_ready=0.
  - start -> FILL. Pointers and occupancy clear to 0 on the same edge.
- FILL:
  - in_ready = (occupancy != IF_LENGTH).
  - A handshake (in_valid & in_ready) produces combinational wr_en=1, wr_addr=wr_ptr, wr_data=in_data.
  - After a handshake, wr_ptr <= (wr_ptr+1 == IF_LENGTH) ? 0 : wr_ptr+1.
  - Handshake with in_last=1 -> DRAIN.
- DRAIN:
  - in_ready=0; releases continue.
  - When occupancy reaches 0: row_done pulses for 1 cycle and the state returns to IDLE.
- Release:
  - On release_valid, eff = min(release_count, occupancy_before).
  - rd_ptr <= (rd_ptr + eff) mod IF_LENGTH, computed in ADDR_WIDTH+1 bits with a single conditional subtract.
  - release_count must be <= IF_LENGTH.
- Occupancy update: occupancy <= occupancy + hs - eff. Write and release in the same cycle are both applied.
- Full: at occupancy==IF_LENGTH, in_ready=0. A same-cycle release does not raise in_ready until the next cycle; in_ready depends only on registered occupancy.
- Empty: release with occupancy 0 has no effect.
- Outputs:
  - IF_start_addr = rd_ptr, zero-extended.
  - window_valid is combinational from registered occupancy and filter_size.
  - filter_size=0 gives window_valid=1 whenever in FILL/DRAIN.
- start outside IDLE is ignored.
- Latency: a write is visible in occupancy, and therefore in window_valid, one cycle after the handshake.

Optional Feature:
- Macro: IFMAP_WR_OVERRUN_CHK_EN.
- With the macro defined:
  - Extra output port ovr_err (1 bit), sticky.
  - Set when release_valid & release_count > occupancy.
  - Set when in_valid is high in DRAIN state.
  - Cleared only by reset or start.
- Without the macro: the port is absent and over-release silently saturates as described above.

Decomposition:
- Shared package ifmap_pkg holds:
  - state encoding constants IDLE=2'd0, FILL=2'd1, DRAIN=2'd2;
  - the default IF_LENGTH, ADDR_WIDTH and DATA_WIDTH constants, shared with the read address generator.
- One natural sub-module: ifmap_ptr_wrap, a modulo-IF_LENGTH pointer adder (ptr + inc, single conditional subtract). Used for both wr_ptr (inc=1) and rd_ptr (inc=eff).

Test Plan:
- Fill to full: IF_LENGTH=12, filter_size=3, start, then 14 words streamed with in_valid=1 and no release.
  - Writes go to addresses 0..11.
  - in_ready drops after the 12th word; occupancy=12.
  - window_valid=1 from the cycle after the 3rd word.
- Wrap: after full, release_count=4 once.
  - IF_start_addr=4 and occupancy=8.
  - The next 4 writes go to addresses 0,1,2,3.
- Simultaneous write and release: occupancy=5, handshake plus release_count=2 in the same cycle -> occupancy=4; rd_ptr advances by 2.
- Over-release: occupancy=2, release_count=5.
  - occupancy=0; rd_ptr advances by 2.
  - With IFMAP_WR_OVERRUN_CHK_EN, ovr_err=1 and it stays 1.
- Row end: in_last on the 6th word.
  - State goes to DRAIN and in_ready=0.
  - Releases 3 then 3 -> row_done pulses once; state returns to IDLE.
- Reset mid-row: rst_n low with occupancy=7 -> all outputs are 0 asynchronously; after release of reset, no wr_en until the next start.
